// File: rtl/pipe_pkg.sv
// Shared constants for pipeline stage registers: payload layout and NOP encoding.
// Also holds the occupancy helper used by the stage register.
package pipe_pkg;

  localparam int PAYLOAD_W = 128;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  // Field offsets inside the packed IR/PC8/AO/RD2 payload
  localparam int IR_LSB  = 96;
  localparam int PC8_LSB = 64;
  localparam int AO_LSB  = 32;
  localparam int RD2_LSB = 0;

  function automatic logic [1:0] occ_count(input logic main_v, input logic skid_v);
    occ_count = {1'b0, main_v} + {1'b0, skid_v};
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One storage slot of a pipeline stage: valid, write-enable and payload.
// Clear always drops the we bit; the payload is zeroed only when ZERO_ON_CLEAR is set.
module pipe_entry
  import pipe_pkg::*;
#(
  parameter int DATA_W        = PAYLOAD_W,
  parameter bit ZERO_ON_CLEAR = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic              d_we,
  input  logic [DATA_W-1:0] d_data,
  output logic              q_valid,
  output logic              q_we,
  output logic [DATA_W-1:0] q_data
);

  logic              valid_r;
  logic              we_r;
  logic [DATA_W-1:0] data_r;

  // Slot state update; clear wins over load
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (clear) begin
      valid_r <= 1'b0;
      we_r    <= 1'b0;
      if (ZERO_ON_CLEAR) begin
        data_r <= {DATA_W{1'b0}};
      end else begin
        data_r <= data_r;
      end
    end else if (load) begin
      valid_r <= 1'b1;
      we_r    <= d_we;
      data_r  <= d_data;
    end else begin
      valid_r <= valid_r;
      we_r    <= we_r;
      data_r  <= data_r;
    end
  end

  assign q_valid = valid_r;
  assign q_we    = we_r;
  assign q_data  = data_r;

endmodule

// File: rtl/pipe_stage_rv.sv
// Valid/ready pipeline stage register with optional two-entry skid buffer,
// synchronous flush and NOP bubbles on empty cycles.
module pipe_stage_rv
  import pipe_pkg::*;
#(
  parameter int DATA_W      = PAYLOAD_W,
  parameter bit SKID        = 1'b1,
  parameter bit BUBBLE_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_we,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_we,
  output logic [1:0]        occupancy
);

  logic              main_valid_s;
  logic              main_we_s;
  logic [DATA_W-1:0] main_data_s;
  logic              main_load_s;
  logic              main_clear_s;
  logic              main_d_we_s;
  logic [DATA_W-1:0] main_d_data_s;
  logic              main_vnext_s;
  logic              skid_vnext_s;
  logic              in_ready_s;
  logic              in_fire_s;
  logic              out_fire_s;
  logic [1:0]        occ_r;

  assign in_fire_s  = in_valid & in_ready_s;
  assign out_fire_s = main_valid_s & out_ready;

  // Drained entries are cleared, so zeroing on clear yields the NOP bubble directly
  pipe_entry #(.DATA_W(DATA_W), .ZERO_ON_CLEAR(BUBBLE_ZERO)) u_main (
    .clk    (clk),
    .reset  (reset),
    .load   (main_load_s),
    .clear  (main_clear_s),
    .d_we   (main_d_we_s),
    .d_data (main_d_data_s),
    .q_valid(main_valid_s),
    .q_we   (main_we_s),
    .q_data (main_data_s)
  );

  generate
    if (SKID) begin : g_skid
      logic              skid_valid_s;
      logic              skid_we_s;
      logic [DATA_W-1:0] skid_data_s;
      logic              skid_load_s;
      logic              skid_clear_s;
      logic              main_from_skid_s;

      pipe_entry #(.DATA_W(DATA_W), .ZERO_ON_CLEAR(BUBBLE_ZERO)) u_skid (
        .clk    (clk),
        .reset  (reset),
        .load   (skid_load_s),
        .clear  (skid_clear_s),
        .d_we   (in_we),
        .d_data (in_data),
        .q_valid(skid_valid_s),
        .q_we   (skid_we_s),
        .q_data (skid_data_s)
      );

      // Main/skid steering; the skid only fills while main is stalled
      always_comb begin
        main_load_s      = 1'b0;
        main_clear_s     = 1'b0;
        main_from_skid_s = 1'b0;
        skid_load_s      = 1'b0;
        skid_clear_s     = 1'b0;
        if (flush) begin
          main_clear_s = 1'b1;
          skid_clear_s = 1'b1;
        end else if (!main_valid_s) begin
          main_load_s = in_fire_s;
        end else if (out_fire_s) begin
          if (skid_valid_s) begin
            main_load_s      = 1'b1;
            main_from_skid_s = 1'b1;
            skid_clear_s     = 1'b1;
          end else if (in_fire_s) begin
            main_load_s = 1'b1;
          end else begin
            main_clear_s = 1'b1;
          end
        end else begin
          skid_load_s = in_fire_s;
        end
      end

      assign main_d_data_s = main_from_skid_s ? skid_data_s : in_data;
      assign main_d_we_s   = main_from_skid_s ? skid_we_s : in_we;
      assign skid_vnext_s  = skid_clear_s ? 1'b0 : (skid_load_s ? 1'b1 : skid_valid_s);
      assign in_ready_s    = ~skid_valid_s;
    end else begin : g_single
      // Single slot: a same-cycle drain and refill replaces the entry
      always_comb begin
        main_load_s  = 1'b0;
        main_clear_s = 1'b0;
        if (flush) begin
          main_clear_s = 1'b1;
        end else if (in_fire_s) begin
          main_load_s = 1'b1;
        end else if (out_fire_s) begin
          main_clear_s = 1'b1;
        end else begin
          main_load_s = 1'b0;
        end
      end

      assign main_d_data_s = in_data;
      assign main_d_we_s   = in_we;
      assign skid_vnext_s  = 1'b0;
      assign in_ready_s    = ~main_valid_s | out_ready;
    end
  endgenerate

  assign main_vnext_s = main_clear_s ? 1'b0 : (main_load_s ? 1'b1 : main_valid_s);

  // Occupancy tracks the post-edge entry state
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_r <= 2'd0;
    end else begin
      occ_r <= occ_count(main_vnext_s, skid_vnext_s);
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = main_valid_s;
  assign out_we    = main_we_s;
  assign out_data  = main_data_s;
  assign occupancy = occ_r;

endmodule

// File: tb/tb_pipe_stage_rv.sv
// Directed bench for pipe_stage_rv: three instances (skid+zero, single entry,
// skid+hold) share one stimulus; each phase checks the relevant instance.
module tb_pipe_stage_rv;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset, in_valid, in_we, flush, out_ready;
  logic [W-1:0] in_data;

  logic         a_in_ready, a_out_valid, a_out_we;
  logic [W-1:0] a_out_data;
  logic [1:0]   a_occ;
  logic         b_in_ready, b_out_valid, b_out_we;
  logic [W-1:0] b_out_data;
  logic [1:0]   b_occ;
  logic         c_in_ready, c_out_valid, c_out_we;
  logic [W-1:0] c_out_data;
  logic [1:0]   c_occ;

  int total = 0;
  int bad   = 0;

  logic [W-1:0] d1, d2, d3, d4, aa;

  pipe_stage_rv #(.DATA_W(W), .SKID(1'b1), .BUBBLE_ZERO(1'b1)) u_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_data(in_data), .in_we(in_we), .flush(flush), .out_valid(a_out_valid),
    .out_ready(out_ready), .out_data(a_out_data), .out_we(a_out_we), .occupancy(a_occ));

  pipe_stage_rv #(.DATA_W(W), .SKID(1'b0), .BUBBLE_ZERO(1'b1)) u_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_data(in_data), .in_we(in_we), .flush(flush), .out_valid(b_out_valid),
    .out_ready(out_ready), .out_data(b_out_data), .out_we(b_out_we), .occupancy(b_occ));

  pipe_stage_rv #(.DATA_W(W), .SKID(1'b1), .BUBBLE_ZERO(1'b0)) u_c (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_data(in_data), .in_we(in_we), .flush(flush), .out_valid(c_out_valid),
    .out_ready(out_ready), .out_data(c_out_data), .out_we(c_out_we), .occupancy(c_occ));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    in_valid = v;
    in_data  = d;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    d1 = 128'h11; d2 = 128'h22; d3 = 128'h33; d4 = 128'h44;
    aa = {16{8'hAA}};
    reset = 1'b1; flush = 1'b0; out_ready = 1'b1; in_we = 1'b1;
    drive(1'b1, aa);

    // Reset with an in-beat offered throughout
    tick(); tick();
    reset = 1'b0;
    drive(1'b0, 128'h0);
    chk("rst_valid", {127'h0, a_out_valid}, 128'h0);
    chk("rst_data", a_out_data, 128'h0);
    chk("rst_we", {127'h0, a_out_we}, 128'h0);
    chk("rst_occ", {126'h0, a_occ}, 128'h0);
    chk("rst_in_ready", {127'h0, a_in_ready}, 128'h1);
    chk("rst_b_occ", {126'h0, b_occ}, 128'h0);
    chk("rst_c_data", c_out_data, 128'h0);

    // Streaming with downstream always ready
    drive(1'b1, d1); tick();
    chk("st_d1", a_out_data, d1);
    chk("st_v1", {127'h0, a_out_valid}, 128'h1);
    chk("st_we1", {127'h0, a_out_we}, 128'h1);
    drive(1'b1, d2); tick();
    chk("st_d2", a_out_data, d2);
    chk("st_v2", {127'h0, a_out_valid}, 128'h1);
    drive(1'b1, d3); tick();
    chk("st_d3", a_out_data, d3);
    chk("st_v3", {127'h0, a_out_valid}, 128'h1);
    drive(1'b1, d4); tick();
    chk("st_d4", a_out_data, d4);
    chk("st_occ4", {126'h0, a_occ}, 128'h1);
    drive(1'b0, 128'h0); tick();
    chk("st_bub_v", {127'h0, a_out_valid}, 128'h0);
    chk("st_bub_d", a_out_data, 128'h0);
    chk("st_bub_we", {127'h0, a_out_we}, 128'h0);

    // Backpressure fills the skid entry
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, d1); tick();
    chk("bp_occ1", {126'h0, a_occ}, 128'h1);
    chk("bp_rdy1", {127'h0, a_in_ready}, 128'h1);
    drive(1'b1, d2); tick();
    chk("bp_occ2", {126'h0, a_occ}, 128'h2);
    chk("bp_rdy2", {127'h0, a_in_ready}, 128'h0);
    chk("bp_out_d1", a_out_data, d1);
    drive(1'b1, d3); tick();
    chk("bp_hold_d1", a_out_data, d1);
    chk("bp_hold_occ", {126'h0, a_occ}, 128'h2);
    out_ready = 1'b1; tick();
    chk("bp_out_d2", a_out_data, d2);
    chk("bp_rdy_back", {127'h0, a_in_ready}, 128'h1);
    chk("bp_occ_after", {126'h0, a_occ}, 128'h1);
    tick();
    chk("bp_out_d3", a_out_data, d3);
    chk("bp_v3", {127'h0, a_out_valid}, 128'h1);
    drive(1'b0, 128'h0); tick();
    chk("bp_empty", {126'h0, a_occ}, 128'h0);

    // Flush while one entry held and an accepted in-beat arrives
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, d1); tick();
    flush = 1'b1; drive(1'b1, d2); tick();
    flush = 1'b0; drive(1'b0, 128'h0);
    chk("fl1_occ", {126'h0, a_occ}, 128'h0);
    chk("fl1_valid", {127'h0, a_out_valid}, 128'h0);

    // Flush with both entries full and an offered beat
    drive(1'b1, d1); tick();
    drive(1'b1, d2); tick();
    chk("fl2_pre_occ", {126'h0, a_occ}, 128'h2);
    flush = 1'b1; drive(1'b1, d3); tick();
    flush = 1'b0; drive(1'b0, 128'h0);
    chk("fl2_occ", {126'h0, a_occ}, 128'h0);
    chk("fl2_valid", {127'h0, a_out_valid}, 128'h0);
    chk("fl2_data", a_out_data, 128'h0);
    chk("fl2_we", {127'h0, a_out_we}, 128'h0);
    out_ready = 1'b1; tick();
    chk("fl2_no_d3", {127'h0, a_out_valid}, 128'h0);

    // Single-entry pass-through with combinational in_ready
    do_reset();
    out_ready = 1'b0;
    drive(1'b1, d1); tick();
    chk("s0_d1", b_out_data, d1);
    chk("s0_occ1", {126'h0, b_occ}, 128'h1);
    drive(1'b1, d2); #1;
    chk("s0_rdy_blocked", {127'h0, b_in_ready}, 128'h0);
    out_ready = 1'b1; #1;
    chk("s0_rdy_comb", {127'h0, b_in_ready}, 128'h1);
    tick();
    chk("s0_d2", b_out_data, d2);
    chk("s0_occ_after", {126'h0, b_occ}, 128'h1);
    chk("s0_v2", {127'h0, b_out_valid}, 128'h1);

    // Hold-last-payload variant drains to an invalid, non-zero bubble
    do_reset();
    out_ready = 1'b1;
    drive(1'b1, 128'h5); tick();
    chk("bz0_d", c_out_data, 128'h5);
    drive(1'b0, 128'h0); tick();
    chk("bz0_valid", {127'h0, c_out_valid}, 128'h0);
    chk("bz0_hold", c_out_data, 128'h5);
    chk("bz0_we", {127'h0, c_out_we}, 128'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
